inst_cache: RTL and testbench

INST_CACHE -- requirements
Module: inst_cache

---
 rtl/inst_cache.sv | 158 +++++++++++++++
 tb/tb_inst_cache.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_cache.sv
// Direct-mapped, one-word-per-line instruction cache with zero-wait hits and refill bypass.
// Optional hit/miss counters are compiled in when ICACHE_STATS_EN is defined.
module inst_cache #(
  parameter int INDEX_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_ce_i,
  input  logic [31:0] cpu_addr_i,
  output logic [31:0] cpu_inst_o,
  output logic        cpu_ready_o,
  input  logic        flush_i,
  output logic        mem_ce_o,
  output logic [31:0] mem_addr_o,
  input  logic [31:0] mem_inst_i,
  input  logic        mem_ready_i
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o
`endif
);

  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = 30 - INDEX_W;

  typedef enum logic {
    IDLE,
    REFILL
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [29:0]      r_addr;
  logic             r_flushed;
  logic [31:0]      r_data  [LINES];
  logic [TAG_W-1:0] r_tag   [LINES];
  logic             r_valid [LINES];

  logic [INDEX_W-1:0] w_index;
  logic [TAG_W-1:0]   w_tag;
  logic [INDEX_W-1:0] w_fill_index;
  logic [TAG_W-1:0]   w_fill_tag;
  logic               w_lookup_hit;
  logic               w_hit;
  logic               w_miss;
  logic               w_fill;
  logic               w_unused_bits;

  assign w_index       = cpu_addr_i[INDEX_W+1:2];
  assign w_tag         = cpu_addr_i[31:INDEX_W+2];
  assign w_fill_index  = r_addr[INDEX_W-1:0];
  assign w_fill_tag    = r_addr[29:INDEX_W];
  assign w_lookup_hit  = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_unused_bits = &{1'b0, cpu_addr_i[1:0]};

  always_comb begin
    w_state_next = r_state;
    cpu_ready_o  = 1'b0;
    cpu_inst_o   = 32'h0;
    mem_ce_o     = 1'b0;
    mem_addr_o   = 32'h0;
    w_hit        = 1'b0;
    w_miss       = 1'b0;
    w_fill       = 1'b0;
    if (!rst) begin
      case (r_state)
        IDLE: begin
          if (cpu_ce_i) begin
            // A flush in the same cycle wins over a matching line.
            if (w_lookup_hit && !flush_i) begin
              w_hit       = 1'b1;
              cpu_ready_o = 1'b1;
              cpu_inst_o  = r_data[w_index];
            end else begin
              w_miss       = 1'b1;
              w_state_next = REFILL;
            end
          end
        end
        REFILL: begin
          mem_ce_o   = 1'b1;
          mem_addr_o = {r_addr, 2'b00};
          if (mem_ready_i) begin
            w_fill       = 1'b1;
            w_state_next = IDLE;
            if (cpu_ce_i && (cpu_addr_i[31:2] == r_addr)) begin
              cpu_ready_o = 1'b1;
              cpu_inst_o  = mem_inst_i;
            end
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // r_flushed remembers a flush seen anywhere in the current refill.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr    <= 30'h0;
      r_flushed <= 1'b0;
    end else if (w_miss) begin
      r_addr    <= cpu_addr_i[31:2];
      r_flushed <= 1'b0;
    end else if ((r_state == REFILL) && flush_i) begin
      r_flushed <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_data[w_fill_index] <= mem_inst_i;
      r_tag[w_fill_index]  <= w_fill_tag;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LINES; gi++) begin : g_valid
      always_ff @(posedge clk) begin
        if (rst || flush_i) begin
          r_valid[gi] <= 1'b0;
        end else if (w_fill && (w_fill_index == INDEX_W'(gi))) begin
          r_valid[gi] <= !r_flushed;
        end
      end
    end
  endgenerate

`ifdef ICACHE_STATS_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_cnt  <= 32'h0;
      r_miss_cnt <= 32'h0;
    end else begin
      if (w_hit) r_hit_cnt <= r_hit_cnt + 32'h1;
      if (w_miss) r_miss_cnt <= r_miss_cnt + 32'h1;
    end
  end

  assign hit_cnt_o  = r_hit_cnt;
  assign miss_cnt_o = r_miss_cnt;
`endif

endmodule

// File: tb/tb_inst_cache.sv
// Self-checking bench for inst_cache: directed scenarios plus randomized fetches
// checked against a per-index model of which word address each line holds.
module tb_inst_cache;
  localparam int IW = 6;
  localparam int NL = 1 << IW;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_ce_i = 1'b0;
  logic [31:0] cpu_addr_i = 32'h0;
  logic [31:0] cpu_inst_o;
  logic        cpu_ready_o;
  logic        flush_i = 1'b0;
  logic        mem_ce_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_inst_i = 32'h0;
  logic        mem_ready_i = 1'b0;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_o;
  logic [31:0] miss_cnt_o;
`endif

  int checks = 0;
  int failures = 0;

  bit          m_valid [NL];
  logic [29:0] m_word  [NL];
  int          m_hits = 0;
  int          m_misses = 0;

  always #5 clk = ~clk;

  inst_cache #(.INDEX_W(IW)) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_ce_i    (cpu_ce_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_inst_o  (cpu_inst_o),
    .cpu_ready_o (cpu_ready_o),
    .flush_i     (flush_i),
    .mem_ce_o    (mem_ce_o),
    .mem_addr_o  (mem_addr_o),
    .mem_inst_i  (mem_inst_i),
    .mem_ready_i (mem_ready_i)
`ifdef ICACHE_STATS_EN
    ,
    .hit_cnt_o   (hit_cnt_o),
    .miss_cnt_o  (miss_cnt_o)
`endif
  );

  function automatic logic [31:0] rom(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w == 32'h0) return 32'h34011100;
    return (w * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  task automatic model_flush();
    for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
  endtask

  task automatic model_reset();
    model_flush();
    m_hits = 0;
    m_misses = 0;
  endtask

  // Apply one cycle of inputs just after the edge, then settle to the falling edge.
  task automatic drive(input bit ce, input logic [31:0] addr, input bit fl,
                       input bit mrdy, input logic [31:0] minst);
    @(posedge clk);
    #1;
    cpu_ce_i    = ce;
    cpu_addr_i  = addr;
    flush_i     = fl;
    mem_ready_i = mrdy;
    mem_inst_i  = minst;
    @(negedge clk);
  endtask

  // One fetch of addr; during refill cycles the core presents alt with enable ce_ref.
  // flush_at: 0 = flush in lookup cycle, k = flush in refill cycle k, -1 = none.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] alt, input bit ce_ref,
                       input int lat, input int flush_at, input string name);
    int idx;
    bit hit;
    bit flushed;
    bit last;
    bit byp;
    logic [31:0] exp_inst;
    idx = int'(addr[IW+1:2]);
    hit = m_valid[idx] && (m_word[idx] == addr[31:2]) && (flush_at != 0);
    drive(1'b1, addr, flush_at == 0, 1'b0, $urandom);
    exp_inst = hit ? rom(addr) : 32'h0;
    checks++;
    if (cpu_ready_o !== hit) begin
      failures++;
      $display("FAIL %s lookup_ready addr=%h got=%b exp=%b", name, addr, cpu_ready_o, hit);
    end
    checks++;
    if (cpu_inst_o !== exp_inst) begin
      failures++;
      $display("FAIL %s lookup_inst addr=%h got=%h exp=%h", name, addr, cpu_inst_o, exp_inst);
    end
    checks++;
    if (mem_ce_o !== 1'b0) begin
      failures++;
      $display("FAIL %s lookup_mem_ce addr=%h got=%b exp=0", name, addr, mem_ce_o);
    end
    if (flush_at == 0) model_flush();
    if (hit) begin
      m_hits++;
      $display("txn %s addr=%h HIT inst=%h", name, addr, cpu_inst_o);
      return;
    end
    m_misses++;
    flushed = 1'b0;
    for (int k = 1; k <= lat; k++) begin
      last = (k == lat);
      byp  = last && ce_ref && (alt[31:2] == addr[31:2]);
      drive(ce_ref, alt, flush_at == k, last, last ? rom(addr) : $urandom);
      exp_inst = byp ? rom(addr) : 32'h0;
      checks++;
      if (mem_ce_o !== 1'b1) begin
        failures++;
        $display("FAIL %s refill_mem_ce cyc=%0d got=%b exp=1", name, k, mem_ce_o);
      end
      checks++;
      if (mem_addr_o !== {addr[31:2], 2'b00}) begin
        failures++;
        $display("FAIL %s refill_mem_addr cyc=%0d got=%h exp=%h", name, k, mem_addr_o,
                 {addr[31:2], 2'b00});
      end
      checks++;
      if (cpu_ready_o !== byp) begin
        failures++;
        $display("FAIL %s refill_ready cyc=%0d got=%b exp=%b", name, k, cpu_ready_o, byp);
      end
      checks++;
      if (cpu_inst_o !== exp_inst) begin
        failures++;
        $display("FAIL %s refill_inst cyc=%0d got=%h exp=%h", name, k, cpu_inst_o, exp_inst);
      end
      if (flush_at == k) begin
        model_flush();
        flushed = 1'b1;
      end
    end
    m_valid[idx] = !flushed;
    m_word[idx]  = addr[31:2];
    $display("txn %s addr=%h MISS lat=%0d alt=%h ce=%0d flush_at=%0d bypass=%0d",
             name, addr, lat, alt, ce_ref, flush_at, byp);
  endtask

  task automatic idle_cycle(input bit fl, input string name);
    drive(1'b0, $urandom, fl, 1'b0, $urandom);
    checks++;
    if ((cpu_ready_o !== 1'b0) || (cpu_inst_o !== 32'h0) || (mem_ce_o !== 1'b0)) begin
      failures++;
      $display("FAIL %s idle got ready=%b inst=%h mem_ce=%b exp 0/0/0", name, cpu_ready_o,
               cpu_inst_o, mem_ce_o);
    end
    if (fl) model_flush();
    $display("txn %s idle flush=%0d", name, fl);
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if ((cpu_ready_o !== 1'b0) || (cpu_inst_o !== 32'h0) || (mem_ce_o !== 1'b0) ||
        (mem_addr_o !== 32'h0)) begin
      failures++;
      $display("FAIL %s in_reset got ready=%b inst=%h mem_ce=%b mem_addr=%h exp all 0", name,
               cpu_ready_o, cpu_inst_o, mem_ce_o, mem_addr_o);
    end
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    cpu_ce_i = 1'b1;
    cpu_addr_i = 32'h0000_0040;
    mem_ready_i = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    cpu_ce_i = 1'b0;
    mem_ready_i = 1'b0;
    model_reset();
    $display("txn reset done");
  endtask

  task automatic test_first_fetch();
    fetch(32'h0, 32'h0, 1'b1, 3, -1, "first_miss");
    fetch(32'h0, 32'h0, 1'b1, 1, -1, "first_rehit");
  endtask

  task automatic test_evict();
    fetch(32'h0000_0004, 32'h0000_0004, 1'b1, 2, -1, "evict_a");
    fetch(32'h0000_0104, 32'h0000_0104, 1'b1, 2, -1, "evict_b");
    fetch(32'h0000_0004, 32'h0000_0004, 1'b1, 1, -1, "evict_a_again");
  endtask

  task automatic test_addr_change();
    fetch(32'h0000_0010, 32'h0000_0020, 1'b1, 3, -1, "addr_change");
    fetch(32'h0000_0020, 32'h0000_0020, 1'b1, 2, -1, "addr_change_next");
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) fetch(32'(i * 4), 32'(i * 4), 1'b1, 1, -1, "flush_fill");
    idle_cycle(1'b1, "flush_pulse");
    fetch(32'h0000_0004, 32'h0000_0004, 1'b1, 2, -1, "flush_refetch4");
    fetch(32'h0000_0008, 32'h0000_0008, 1'b1, 3, 2, "flush_mid_refill8");
    fetch(32'h0000_0008, 32'h0000_0008, 1'b1, 1, -1, "flush_refetch8");
    fetch(32'h0000_000C, 32'h0000_000C, 1'b1, 2, 2, "flush_at_ready");
    fetch(32'h0000_000C, 32'h0000_000C, 1'b1, 1, -1, "flush_refetchC");
  endtask

  task automatic test_ce_low();
    idle_cycle(1'b0, "ce_low0");
    idle_cycle(1'b0, "ce_low1");
    fetch(32'h0000_0030, 32'h0000_0030, 1'b0, 3, -1, "ce_drop_refill");
    fetch(32'h0000_0031, 32'h0000_0031, 1'b1, 1, -1, "ce_drop_rehit");
  endtask

  task automatic test_rst_mid_refill();
    fetch(32'h0000_0044, 32'h0000_0044, 1'b1, 1, -1, "rst_prefill");
    drive(1'b1, 32'h1234_0040, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 32'h1234_0040, 1'b0, 1'b0, 32'h0);
    checks++;
    if (mem_ce_o !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid refill_started got mem_ce=%b exp=1", mem_ce_o);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_mid");
    @(posedge clk);
    #1;
    rst = 1'b0;
    cpu_ce_i = 1'b0;
    model_reset();
    @(negedge clk);
    checks++;
    if (mem_ce_o !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid after_reset_mem_ce got=%b exp=0", mem_ce_o);
    end
    $display("txn rst_mid refill dropped");
    fetch(32'h0000_0044, 32'h0000_0044, 1'b1, 2, -1, "rst_refetch");
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] alt;
    int fl;
    for (int n = 0; n < 80; n++) begin
      a = (32'($urandom_range(0, 3)) << (IW + 2)) | (32'($urandom_range(0, 7)) << 2) |
          32'($urandom_range(0, 3));
      alt = ($urandom_range(0, 3) != 0) ? {a[31:2], 2'($urandom_range(0, 3))} : $urandom;
      fl = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 2) : -1;
      fetch(a, alt, $urandom_range(0, 4) != 0, $urandom_range(1, 4), fl, "random");
      if ($urandom_range(0, 7) == 0) idle_cycle($urandom_range(0, 3) == 0, "random_idle");
    end
  endtask

  task automatic test_stats();
`ifdef ICACHE_STATS_EN
    checks++;
    if ((hit_cnt_o !== 32'(m_hits)) || (miss_cnt_o !== 32'(m_misses))) begin
      failures++;
      $display("FAIL stats got hit=%0d miss=%0d exp hit=%0d miss=%0d", hit_cnt_o, miss_cnt_o,
               m_hits, m_misses);
    end
    $display("txn stats hit=%0d miss=%0d", hit_cnt_o, miss_cnt_o);
`endif
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_evict();
    test_addr_change();
    test_flush();
    test_ce_low();
    test_stats();
    test_rst_mid_refill();
    test_random();
    idle_cycle(1'b0, "final_idle");
    test_stats();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
